// File: rtl/flags_ctrl.sv
// rtl/flags_ctrl.sv - NZCV/Q flags register with multi-cycle flag-write scoreboard and decode stall
module flags_ctrl #(
    parameter int MAX_PEND = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ExValid,
    input  logic             ExCondEx,
    input  logic [1:0]       ExFlagsWrite,
    input  logic [4:0]       ExALUFlags,
    input  logic             MulIssue,
    input  logic             MulDone,
    input  logic [4:0]       MulFlags,
    input  logic [3:0]       DCond,
    input  logic [1:0]       DFlagsWrite,
    input  logic             DIsMul,
    input  logic             SatClr,
    output logic [3:0]       Flags,
    output logic             Sat,
    output logic             DStall,
    output logic [1:0]       PendMask,
    output logic [CNT_W-1:0] PendCount,
    output logic             Err
);

    localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;

    // Pending-write scoreboard: each entry is the group mask {NZ,CV} of one multi-cycle writer
    logic [1:0]       r_fifo [MAX_PEND];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [3:0]       r_flags;
    logic             r_sat;
    logic             r_err;

    logic [1:0]       w_wm;
    logic             w_alu;
    logic [1:0]       w_alu_wm;
    logic             w_empty;
    logic             w_full;
    logic             w_push_req;
    logic             w_pop;
    logic             w_push;
    logic [1:0]       w_head_mask;
    logic [1:0]       w_pend_mask;
    logic [1:0]       w_rest_mask;
    logic [1:0]       w_hazard;
    logic [1:0]       w_need;
    logic [3:0]       w_flags_nxt;
    logic             w_q_set;
    logic             w_err_set;
    logic [PTR_W-1:0] w_idx;

    assign w_wm        = ExFlagsWrite & {2{ExCondEx}};
    assign w_alu       = ExValid & ~MulIssue;
    assign w_alu_wm    = w_wm & {2{w_alu}};
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(MAX_PEND));
    assign w_push_req  = ExValid & MulIssue & (w_wm != 2'b00);
    assign w_pop       = MulDone & ~w_empty;
    // A full FIFO still accepts a push when the head leaves in the same edge
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_head_mask = r_fifo[r_head];

    // OR of all occupied entries, and of all but the head (what remains after a pop)
    always_comb begin
        w_pend_mask = 2'b00;
        w_rest_mask = 2'b00;
        w_idx       = '0;
        for (int i = 0; i < MAX_PEND; i++) begin
            w_idx = r_head + PTR_W'(i);
            if (CNT_W'(i) < r_count) begin
                w_pend_mask = w_pend_mask | r_fifo[w_idx];
                if (i != 0) begin
                    w_rest_mask = w_rest_mask | r_fifo[w_idx];
                end
            end
        end
    end

    // Flag groups the decode instruction's condition reads, as {NZ,CV}
    always_comb begin
        w_need = 2'b00;
        case (DCond)
            4'b0000, 4'b0001, 4'b0100, 4'b0101: w_need = 2'b10;
            4'b0010, 4'b0011, 4'b0110, 4'b0111: w_need = 2'b01;
            4'b1000, 4'b1001, 4'b1010, 4'b1011,
            4'b1100, 4'b1101:                   w_need = 2'b11;
            default:                            w_need = 2'b00;
        endcase
    end

    // Groups still outstanding after this edge: survivors of a pop plus an accepted push
    assign w_hazard = (w_pop ? w_rest_mask : w_pend_mask) | (w_push ? w_wm : 2'b00);

    assign DStall = (((w_need | DFlagsWrite) & w_hazard) != 2'b00)
                  | (DIsMul & w_full & ~MulDone);

    // Next flag value: multi-cycle result first, ALU result overrides on any overlap
    always_comb begin
        w_flags_nxt = r_flags;
        if (w_pop) begin
            if (w_head_mask[1]) begin
                w_flags_nxt[3:2] = MulFlags[3:2];
            end
            if (w_head_mask[0]) begin
                w_flags_nxt[1:0] = MulFlags[1:0];
            end
        end
        if (w_alu_wm[1]) begin
            w_flags_nxt[3:2] = ExALUFlags[3:2];
        end
        if (w_alu_wm[0]) begin
            w_flags_nxt[1:0] = ExALUFlags[1:0];
        end
    end

    assign w_q_set   = (w_alu & ExCondEx & ExALUFlags[4]) | (w_pop & MulFlags[4]);
    assign w_err_set = (w_push_req & w_full & ~w_pop)
                     | (MulDone & w_empty)
                     | (w_pop & ((w_alu_wm & w_head_mask) != 2'b00));

    // Scoreboard pointers, occupancy and entry storage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_tail] <= w_wm;
                r_tail         <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Architectural flags, sticky saturation (set beats clear) and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
            r_sat   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_flags <= w_flags_nxt;
            if (w_q_set) begin
                r_sat <= 1'b1;
            end else if (SatClr) begin
                r_sat <= 1'b0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign Flags     = r_flags;
    assign Sat       = r_sat;
    assign PendMask  = w_pend_mask;
    assign PendCount = r_count;
    assign Err       = r_err;

endmodule

// File: tb/tb_flags_ctrl.sv
// tb/tb_flags_ctrl.sv - scoreboard bench for flags_ctrl
module tb_flags_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ExValid;
    logic       ExCondEx;
    logic [1:0] ExFlagsWrite;
    logic [4:0] ExALUFlags;
    logic       MulIssue;
    logic       MulDone;
    logic [4:0] MulFlags;
    logic [3:0] DCond;
    logic [1:0] DFlagsWrite;
    logic       DIsMul;
    logic       SatClr;
    logic [3:0] Flags;
    logic       Sat;
    logic       DStall;
    logic [1:0] PendMask;
    logic [2:0] PendCount;
    logic       Err;

    localparam int S_FLAGS = 0;
    localparam int S_SAT   = 1;
    localparam int S_STALL = 2;
    localparam int S_PMASK = 3;
    localparam int S_PCNT  = 4;
    localparam int S_ERR   = 5;

    typedef struct {
        string      name;
        int         cyc;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   mon_n;
    exp_t mon_e;

    flags_ctrl #(.MAX_PEND(4), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .ExValid      (ExValid),
        .ExCondEx     (ExCondEx),
        .ExFlagsWrite (ExFlagsWrite),
        .ExALUFlags   (ExALUFlags),
        .MulIssue     (MulIssue),
        .MulDone      (MulDone),
        .MulFlags     (MulFlags),
        .DCond        (DCond),
        .DFlagsWrite  (DFlagsWrite),
        .DIsMul       (DIsMul),
        .SatClr       (SatClr),
        .Flags        (Flags),
        .Sat          (Sat),
        .DStall       (DStall),
        .PendMask     (PendMask),
        .PendCount    (PendCount),
        .Err          (Err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(int s);
        case (s)
            S_FLAGS: return {4'b0000, Flags};
            S_SAT:   return {7'b0, Sat};
            S_STALL: return {7'b0, DStall};
            S_PMASK: return {6'b0, PendMask};
            S_PCNT:  return {5'b0, PendCount};
            default: return {7'b0, Err};
        endcase
    endfunction

    // Monitor: compare every expectation that falls due in the current cycle
    always @(negedge clk) begin
        mon_n = sb.size();
        for (int k = 0; k < mon_n; k++) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc == cyc) begin
                checks = checks + 1;
                if (actual(mon_e.sel) !== mon_e.exp) begin
                    errors = errors + 1;
                    $display("FAIL %s (cycle %0d): got %0h expected %0h",
                             mon_e.name, cyc, actual(mon_e.sel), mon_e.exp);
                end
            end else if (mon_e.cyc < cyc) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL %s: expectation for cycle %0d never sampled", mon_e.name, mon_e.cyc);
            end else begin
                sb.push_back(mon_e);
            end
        end
    end

    task automatic exp_now(string n, int s, logic [7:0] v);
        sb.push_back('{n, cyc, s, v});
    endtask

    task automatic exp_nxt(string n, int s, logic [7:0] v);
        sb.push_back('{n, cyc + 1, s, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ExValid      = 1'b0;
        ExCondEx     = 1'b0;
        ExFlagsWrite = 2'b00;
        ExALUFlags   = 5'b0;
        MulIssue     = 1'b0;
        MulDone      = 1'b0;
        MulFlags     = 5'b0;
        DCond        = 4'b1110;
        DFlagsWrite  = 2'b00;
        DIsMul       = 1'b0;
        SatClr       = 1'b0;
    endtask

    task automatic push_mul(logic [1:0] fw);
        idle();
        ExValid      = 1'b1;
        ExCondEx     = 1'b1;
        MulIssue     = 1'b1;
        ExFlagsWrite = fw;
    endtask

    task automatic check_reset_state(string tag);
        exp_now({tag, "_flags"}, S_FLAGS, 8'h0);
        exp_now({tag, "_sat"},   S_SAT,   8'h0);
        exp_now({tag, "_pcnt"},  S_PCNT,  8'h0);
        exp_now({tag, "_pmask"}, S_PMASK, 8'h0);
        exp_now({tag, "_err"},   S_ERR,   8'h0);
        exp_now({tag, "_stall"}, S_STALL, 8'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_reset_state("rst");

        // ALU writes
        ExValid = 1'b1; ExCondEx = 1'b1; ExFlagsWrite = 2'b11; ExALUFlags = 5'b0_1010;
        exp_nxt("alu_both", S_FLAGS, 8'hA);
        step();
        ExFlagsWrite = 2'b01; ExALUFlags = 5'b0_0101;
        exp_nxt("alu_cv", S_FLAGS, 8'h9);
        exp_nxt("alu_cv_sat", S_SAT, 8'h0);
        step();

        // Condition failed: nothing changes
        ExCondEx = 1'b0; ExFlagsWrite = 2'b11; ExALUFlags = 5'b1_1111;
        exp_nxt("condfail_flags", S_FLAGS, 8'h9);
        exp_nxt("condfail_sat", S_SAT, 8'h0);
        step();

        // RAW stall on NZ
        push_mul(2'b10); DCond = 4'b0000;
        exp_now("raw_push_stall", S_STALL, 8'h1);
        exp_nxt("raw_pcnt", S_PCNT, 8'h1);
        exp_nxt("raw_pmask", S_PMASK, 8'h2);
        step();
        idle(); DCond = 4'b0000;
        exp_now("raw_wait1", S_STALL, 8'h1);
        step();
        exp_now("raw_wait2", S_STALL, 8'h1);
        step();
        MulDone = 1'b1; MulFlags = 5'b1_0100;
        exp_now("raw_done_stall", S_STALL, 8'h0);
        exp_nxt("raw_done_flags", S_FLAGS, 8'h5);
        exp_nxt("raw_done_sat", S_SAT, 8'h1);
        exp_nxt("raw_done_pcnt", S_PCNT, 8'h0);
        exp_nxt("raw_done_err", S_ERR, 8'h0);
        step();

        // Disjoint groups
        push_mul(2'b10);
        exp_now("dis_push_al", S_STALL, 8'h0);
        step();
        idle(); DCond = 4'b0010;
        exp_now("dis_cs", S_STALL, 8'h0);
        exp_now("dis_pmask", S_PMASK, 8'h2);
        step();
        DCond = 4'b1100;
        exp_now("dis_gt", S_STALL, 8'h1);
        step();
        DCond = 4'b0010; DFlagsWrite = 2'b10;
        exp_now("dis_waw", S_STALL, 8'h1);
        step();
        idle(); MulDone = 1'b1; MulFlags = 5'b0_0000;
        exp_nxt("dis_pop_flags", S_FLAGS, 8'h1);
        exp_nxt("dis_pop_sat", S_SAT, 8'h1);
        step();

        // Sticky Q clear, and set beating clear
        idle(); SatClr = 1'b1;
        exp_nxt("satclr", S_SAT, 8'h0);
        step();
        ExValid = 1'b1; ExCondEx = 1'b1; ExALUFlags = 5'b1_0000;
        exp_nxt("satset_wins", S_SAT, 8'h1);
        exp_nxt("satset_flags", S_FLAGS, 8'h1);
        step();
        idle(); SatClr = 1'b1;
        exp_nxt("satclr2", S_SAT, 8'h0);
        step();

        // Fill the FIFO
        push_mul(2'b10); step();
        push_mul(2'b01); step();
        push_mul(2'b11); step();
        push_mul(2'b10);
        exp_nxt("full_pcnt", S_PCNT, 8'h4);
        exp_nxt("full_pmask", S_PMASK, 8'h3);
        step();
        push_mul(2'b01); DIsMul = 1'b1;
        exp_now("full_dismul_stall", S_STALL, 8'h1);
        exp_nxt("full_drop_err", S_ERR, 8'h1);
        exp_nxt("full_drop_pcnt", S_PCNT, 8'h4);
        step();
        push_mul(2'b11); DIsMul = 1'b1; MulDone = 1'b1; MulFlags = 5'b1_1100;
        exp_now("full_pushpop_stall", S_STALL, 8'h0);
        exp_nxt("full_pushpop_pcnt", S_PCNT, 8'h4);
        exp_nxt("full_pushpop_flags", S_FLAGS, 8'hD);
        exp_nxt("full_pushpop_sat", S_SAT, 8'h1);
        step();
        idle(); MulDone = 1'b1; MulFlags = 5'b0_0000;
        exp_nxt("pop_cv_flags", S_FLAGS, 8'hC);
        exp_nxt("pop_cv_pcnt", S_PCNT, 8'h3);
        step();

        // Reset with three pending
        idle(); reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state("midrst");
        MulDone = 1'b1;
        exp_nxt("stale_done_err", S_ERR, 8'h1);
        exp_nxt("stale_done_pcnt", S_PCNT, 8'h0);
        step();

        // ALU and pop to the same group: ALU wins, Err set
        idle(); reset = 1'b1;
        step();
        reset = 1'b0;
        push_mul(2'b10);
        exp_now("coll_pre_err", S_ERR, 8'h0);
        step();
        idle();
        ExValid = 1'b1; ExCondEx = 1'b1; ExFlagsWrite = 2'b10; ExALUFlags = 5'b0_1000;
        MulDone = 1'b1; MulFlags = 5'b0_0100;
        exp_nxt("coll_flags", S_FLAGS, 8'h8);
        exp_nxt("coll_err", S_ERR, 8'h1);
        exp_nxt("coll_pcnt", S_PCNT, 8'h0);
        step();
        idle();
        step();
        step();
        @(negedge clk);
        #1;
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
